// File: rtl/nn_pkg.sv
// Shared definitions for the softmax epoch controller:
// the FSM state encoding and a constant clog2 used for counter and index widths.
package nn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SCAN = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_stream_counter.sv
// Per-class ones counter for one stochastic bitstream.
// Ports: CLK, INIT (async reset), clr (sync clear), en (count enable),
// bit_in (stream bit), count (ones seen since the last clear).
module nn_stream_counter #(
    parameter int CW = 9
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] count
);

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && bit_in) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/nn_softmax_epoch_ctrl.sv
// Epoch controller for a stochastic softmax layer: counts ones on N class
// bitstreams over WINDOW cycles, then scans sequentially for the argmax.
// Ports: CLK, INIT (async reset), start, abort, z[N], ready in;
// stream_en, busy, valid, winner, winner_count, tie out.
module nn_softmax_epoch_ctrl
    import nn_pkg::*;
#(
    parameter int N      = 3,
    parameter int WINDOW = 256,
    parameter int CW     = clog2(WINDOW + 1),
    parameter int IW     = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  z,
    input  logic          ready,
    output logic          stream_en,
    output logic          busy,
    output logic          valid,
    output logic [IW-1:0] winner,
    output logic [CW-1:0] winner_count,
    output logic          tie
);

    state_t        state;
    state_t        state_nxt;
    logic          clr_cnt;
    logic          cnt_en;
    logic          cyc_last;
    logic          scan_last;
    logic [CW-1:0] cyc;
    logic [IW-1:0] scan_idx;
    logic [CW-1:0] cnt [N];
    logic [CW-1:0] sel;

    for (genvar g = 0; g < N; g++) begin : g_cnt
        nn_stream_counter #(
            .CW(CW)
        ) u_cnt (
            .CLK   (CLK),
            .INIT  (INIT),
            .clr   (clr_cnt),
            .en    (cnt_en),
            .bit_in(z[g]),
            .count (cnt[g])
        );
    end

    assign cyc_last  = (cyc == CW'(WINDOW - 1));
    assign scan_last = (scan_idx == IW'(N - 1));
    assign sel       = cnt[scan_idx];

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clr_cnt   = 1'b1;
                end
            end
            S_RUN: begin
                // abort wins over the sample on the same edge
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cyc_last) begin
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ready) begin
                    if (start) begin
                        state_nxt = S_RUN;
                        clr_cnt   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stream_en = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign valid     = (state == S_HOLD);

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            cyc <= '0;
        end else if (clr_cnt) begin
            cyc <= '0;
        end else if (cnt_en) begin
            cyc <= cyc + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            scan_idx <= '0;
        end else if (state == S_RUN) begin
            scan_idx <= '0;
        end else if (state == S_SCAN) begin
            scan_idx <= scan_idx + IW'(1);
        end
    end

    // Sequential argmax: ties keep the lower index, which is the one
    // already held because classes are visited in ascending order.
    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            winner       <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else if (state == S_SCAN) begin
            if (scan_idx == '0 || sel > winner_count) begin
                winner       <= scan_idx;
                winner_count <= sel;
                tie          <= 1'b0;
            end else if (sel == winner_count) begin
                tie <= 1'b1;
            end
        end
    end

endmodule

// File: doc/nn_softmax_epoch_ctrl.md
NN_SOFTMAX_EPOCH_CTRL -- requirements
Module: nn_softmax_epoch_ctrl

Interface
REQ-001 Parameter N, 3, number of softmax output classes (z bitstreams); N >= 2.
REQ-002 Parameter WINDOW, 256, bitstream evaluation length in clock cycles; WINDOW >= 2.
REQ-003 Parameter CW, clog2(WINDOW+1), per-class ones-counter width; IW = max(1, clog2(N)) is the index width.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 INIT  input  1  asynchronous active-high reset.
REQ-007 start  input  1  request one evaluation epoch; sampled only in IDLE.
REQ-008 abort  input  1  cancel the epoch in progress; sampled only in RUN.
REQ-009 z  input  N  per-class stochastic softmax node outputs, one bit per class per cycle.
REQ-010 ready  input  1  downstream accepts the result.
REQ-011 stream_en  output  1  enables upstream stochastic number generators and node datapath.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 valid  output  1  result available.
REQ-014 winner  output  IW  index of the class with the highest ones count.
REQ-015 winner_count  output  CW  ones count of the winning class.
REQ-016 tie  output  1  another class matched the winning count.

Function
REQ-017 States SHALL be IDLE, RUN, SCAN and HOLD.
REQ-018 IDLE with start=1 at an edge SHALL go to RUN, clearing all N counters and the cycle counter at that edge.
REQ-019 In RUN, stream_en SHALL be 1; at each edge, counter[n] SHALL increment by z[n], and the cycle counter SHALL increment.
REQ-020 RUN SHALL sample z on exactly WINDOW edges, then go to SCAN on the WINDOW-th sampling edge.
REQ-021 Counters SHALL never wrap, because CW holds WINDOW; a count equal to WINDOW is legal.
REQ-022 In RUN, abort=1 SHALL return to IDLE at the next edge without asserting valid; z is ignored on that edge.
REQ-023 SCAN SHALL take exactly N cycles, examining class i (i = 0..N-1) in cycle i.
REQ-024 In SCAN, class 0 SHALL initialize the running max; a strictly greater count SHALL replace the max and index and clear tie; an equal count SHALL set tie and keep the lower index.
REQ-025 After class N-1, the state SHALL go to HOLD; valid SHALL first be high WINDOW+N cycles after the edge that sampled start.
REQ-026 In HOLD, valid=1, and winner, winner_count and tie SHALL be held stable until valid&ready at an edge.
REQ-027 On valid&ready, the state SHALL go to IDLE; if start=1 on that same edge, it SHALL go directly to RUN with counters cleared (back-to-back epochs).
REQ-028 start outside IDLE (except the REQ-027 edge) and abort outside RUN SHALL be ignored.
REQ-029 stream_en SHALL be 0 in IDLE, SCAN and HOLD; busy SHALL equal (state != IDLE).
REQ-030 winner, winner_count and tie SHALL retain their last HOLD values in IDLE until the next SCAN updates them.

Reset
REQ-031 INIT=1 SHALL immediately force IDLE, and valid, stream_en, busy, tie, winner and winner_count SHALL all be 0, independent of CLK.
REQ-032 INIT asserted mid-RUN, mid-SCAN or mid-HOLD SHALL discard the epoch; after deassertion the first start SHALL behave as from power-up.

Structure
REQ-033 A shared package nn_pkg SHALL hold the state encoding constants and the clog2 function used for CW and IW.
REQ-034 Per-class counting SHALL be a sub-module nn_stream_counter (ports CLK, INIT, clr, en, bit_in, count), instantiated N times in a generate loop.
REQ-035 The FSM, cycle counter and sequential argmax SHALL live in nn_softmax_epoch_ctrl.

Verification (N=3, WINDOW=16)
REQ-036 z[0]=0, z[1]=1, z[2] alternating over the window -> winner=1, winner_count=16, tie=0; valid rises 19 cycles after start.
REQ-037 z[0] and z[2] each with 8 ones, z[1] with 4 ones -> winner=0, winner_count=8, tie=1.
REQ-038 ready held low 10 cycles in HOLD, with start pulsed -> valid and the outputs remain stable and start is ignored; ready=1 -> IDLE next edge.
REQ-039 start=1 on the handshake edge -> RUN next cycle, stream_en=1, and the new result is independent of the prior counts.
REQ-040 INIT pulsed at RUN cycle 7 -> outputs 0 without waiting for a clock edge; a later start with z[2]=1 only -> winner=2, winner_count=16.
REQ-041 abort at RUN cycle 5 -> IDLE next edge, stream_en=0, and valid never asserts.
